// File: rtl/ysyx_22050612_ifu.sv
// ysyx_22050612 RV64 multi-cycle instruction fetch unit.
// Optional misaligned-PC fault: define YSYX_22050612_IFU_MISALIGN_CHECK_EN.
module ysyx_22050612_ifu #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        commit_valid,
    input  logic [63:0] commit_dnpc,
    output logic [63:0] inst_count,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
`ifdef YSYX_22050612_IFU_MISALIGN_CHECK_EN
        S_EXEC  = 3'd4,
        S_FAULT = 3'd5
`else
        S_EXEC  = 3'd4
`endif
    } state_t;

    state_t      r_state;
    logic [63:0] r_pc;
    logic [31:0] r_inst;
    logic [63:0] r_count;
    logic        r_req_valid;
    logic        r_inst_valid;

    logic        w_req_fire;
    logic [31:0] w_rsp_word;
    logic [63:0] w_dnpc_aligned;

    assign w_req_fire     = r_req_valid & mem_req_ready;
    assign w_rsp_word     = r_pc[2] ? mem_rsp_data[63:32] : mem_rsp_data[31:0];
    assign w_dnpc_aligned = commit_dnpc & ~64'h3;

`ifdef YSYX_22050612_IFU_MISALIGN_CHECK_EN
    logic r_fault;
    logic w_misalign;

    assign w_misalign = |commit_dnpc[1:0];
    assign fault      = r_fault;

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (r_state == S_EXEC && commit_valid && w_misalign) begin
            r_fault <= 1'b1;
        end
    end
`else
    assign fault = 1'b0;
`endif

    // Fetch sequencer: owns PC, fetched word, counter and handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_inst       <= 32'h0;
            r_count      <= 64'h0;
            r_req_valid  <= 1'b0;
            r_inst_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_state     <= S_REQ;
                    r_req_valid <= 1'b1;
                end
                S_REQ: begin
                    if (w_req_fire) begin
                        r_state     <= S_WAIT;
                        r_req_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        r_inst       <= w_rsp_word;
                        r_state      <= S_OUT;
                        r_inst_valid <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (inst_ready) begin
                        r_count      <= r_count + 64'd1;
                        r_state      <= S_EXEC;
                        r_inst_valid <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (commit_valid) begin
`ifdef YSYX_22050612_IFU_MISALIGN_CHECK_EN
                        r_pc <= commit_dnpc;
                        if (w_misalign) begin
                            r_state <= S_FAULT;
                        end else begin
                            r_state     <= S_REQ;
                            r_req_valid <= 1'b1;
                        end
`else
                        r_pc        <= w_dnpc_aligned;
                        r_state     <= S_REQ;
                        r_req_valid <= 1'b1;
`endif
                    end
                end
`ifdef YSYX_22050612_IFU_MISALIGN_CHECK_EN
                S_FAULT: begin
                    r_state <= S_FAULT;
                end
`endif
                default: begin
                    r_state      <= S_IDLE;
                    r_req_valid  <= 1'b0;
                    r_inst_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_valid = r_req_valid;
    assign mem_req_addr  = {r_pc[63:3], 3'b000};
    assign inst_valid    = r_inst_valid;
    assign inst          = r_inst;
    assign inst_pc       = r_pc;
    assign inst_count    = r_count;

`ifndef YSYX_22050612_IFU_MISALIGN_CHECK_EN
    // Low PC bits are discarded here; keep them referenced for lint.
    logic w_unused;
    assign w_unused = &{1'b0, w_dnpc_aligned[1:0]};
`endif

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Directed testbench for ysyx_22050612_ifu with a cycle model
// checked every cycle plus literal expectations.
module tb_ysyx_22050612_ifu;

    localparam logic [63:0] RPC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        commit_valid;
    logic [63:0] commit_dnpc;
    logic [63:0] inst_count;
    logic        fault;

    ysyx_22050612_ifu #(.RESET_PC(RPC)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .commit_valid (commit_valid),
        .commit_dnpc  (commit_dnpc),
        .inst_count   (inst_count),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    // Model: which phase of the fetch loop the unit is in.
    localparam int P_IDLE  = 0;
    localparam int P_REQ   = 1;
    localparam int P_WAIT  = 2;
    localparam int P_OUT   = 3;
    localparam int P_EXEC  = 4;
    localparam int P_FAULT = 5;

    int          m_ph    = P_IDLE;
    logic [63:0] m_pc    = RPC;
    logic [31:0] m_inst  = 32'h0;
    logic [63:0] m_cnt   = 64'h0;
    logic        m_fault = 1'b0;
    int          cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph    <= P_IDLE;
            m_pc    <= RPC;
            m_inst  <= 32'h0;
            m_cnt   <= 64'h0;
            m_fault <= 1'b0;
        end else begin
            case (m_ph)
                P_IDLE: m_ph <= P_REQ;
                P_REQ:  if (mem_req_ready) m_ph <= P_WAIT;
                P_WAIT: if (mem_rsp_valid) begin
                    m_inst <= m_pc[2] ? mem_rsp_data[63:32] : mem_rsp_data[31:0];
                    m_ph   <= P_OUT;
                end
                P_OUT: if (inst_ready) begin
                    m_cnt <= m_cnt + 1;
                    m_ph  <= P_EXEC;
                end
                P_EXEC: if (commit_valid) begin
`ifdef YSYX_22050612_IFU_MISALIGN_CHECK_EN
                    m_pc <= commit_dnpc;
                    if (commit_dnpc[1:0] != 2'b00) begin
                        m_fault <= 1'b1;
                        m_ph    <= P_FAULT;
                    end else begin
                        m_ph <= P_REQ;
                    end
`else
                    m_pc <= commit_dnpc & ~64'h3;
                    m_ph <= P_REQ;
`endif
                end
                default: m_ph <= m_ph;
            endcase
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("req_valid", {63'b0, mem_req_valid}, {63'b0, m_ph == P_REQ});
        if (m_ph == P_REQ)
            chk("req_addr", mem_req_addr, {m_pc[63:3], 3'b000});
        chk("inst_valid", {63'b0, inst_valid}, {63'b0, m_ph == P_OUT});
        chk("inst", {32'b0, inst}, {32'b0, m_inst});
        chk("inst_pc", inst_pc, m_pc);
        chk("inst_count", inst_count, m_cnt);
        chk("fault", {63'b0, fault}, {63'b0, m_fault});
    end

    logic [63:0] seen_addr;
    logic [31:0] seen_inst;
    logic [63:0] seen_pc;

    // Entered at a falling edge with the unit in REQ.
    task automatic run_one(input logic [63:0] data, input int rs,
                           input int os, input bit spur,
                           input logic [63:0] dnpc);
        seen_addr = mem_req_addr;
        mem_req_ready = 1'b0;
        for (int i = 0; i < rs; i++) begin
            mem_rsp_valid = spur && (i == 0);
            mem_rsp_data  = 64'hdead_beef_dead_beef;
            @(negedge clk);
        end
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        seen_inst = inst;
        seen_pc   = inst_pc;
        for (int i = 0; i < os; i++) begin
            commit_valid = spur && (i == 0);
            commit_dnpc  = 64'h9000_0000;
            @(negedge clk);
        end
        commit_valid = 1'b0;
        inst_ready   = 1'b1;
        @(negedge clk);
        inst_ready   = 1'b0;
        commit_valid = 1'b1;
        commit_dnpc  = dnpc;
        @(negedge clk);
        commit_valid = 1'b0;
    endtask

    int c0;

    initial begin
        rst           = 1'b1;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 64'h0;
        inst_ready    = 1'b0;
        commit_valid  = 1'b0;
        commit_dnpc   = 64'h0;
        repeat (3) @(negedge clk);
        chk("rst_req_valid", {63'b0, mem_req_valid}, 64'd0);
        chk("rst_inst_valid", {63'b0, inst_valid}, 64'd0);
        chk("rst_inst", {32'b0, inst}, 64'd0);
        chk("rst_pc", inst_pc, 64'h8000_0000);
        chk("rst_count", inst_count, 64'd0);

        mem_req_ready = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("first_req_valid", {63'b0, mem_req_valid}, 64'd1);
        chk("first_addr", mem_req_addr, 64'h8000_0000);

        run_one(64'h1111_1111_0000_0413, 0, 0, 1'b0, 64'h8000_0004);
        chk("t1_inst", {32'b0, seen_inst}, 64'h0000_0413);
        chk("t1_pc", seen_pc, 64'h8000_0000);
        chk("t1_count", inst_count, 64'd1);

        run_one(64'h00a0_0513_dead_beef, 0, 0, 1'b0, 64'h8000_0010);
        chk("t2_addr", seen_addr, 64'h8000_0000);
        chk("t2_pc", seen_pc, 64'h8000_0004);
        chk("t2_inst", {32'b0, seen_inst}, 64'h00a0_0513);

        run_one(64'h0000_0000_0010_0093, 5, 5, 1'b1, 64'h8000_0010);
        chk("t3_inst", {32'b0, seen_inst}, 64'h0010_0093);
        chk("t3_count", inst_count, 64'd3);

        run_one(64'h0000_0013_ffff_ffff, 0, 0, 1'b0, 64'h8000_0018);
        chk("t4_refetch_addr", seen_addr, 64'h8000_0010);
        chk("t4_inst", {32'b0, seen_inst}, 64'hffff_ffff);
        chk("t4_count", inst_count, 64'd4);

        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        chk("midrst_count", inst_count, 64'd0);
        chk("midrst_pc", inst_pc, 64'h8000_0000);
        rst = 1'b0;
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h5555_5555_5555_5555;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("stale_inst", {32'b0, inst}, 64'd0);
        chk("stale_req_valid", {63'b0, mem_req_valid}, 64'd1);
        chk("stale_pc", inst_pc, 64'h8000_0000);

        c0 = cyc;
        run_one(64'h0020_0113_0010_0093, 0, 0, 1'b0, 64'h8000_0004);
        chk("l1_inst", {32'b0, seen_inst}, 64'h0010_0093);
        run_one(64'h0020_0113_0010_0093, 0, 0, 1'b0, 64'h8000_0008);
        chk("l2_inst", {32'b0, seen_inst}, 64'h0020_0113);
        run_one(64'h0000_0000_0030_0193, 0, 0, 1'b0, 64'h8000_0002);
        chk("l3_inst", {32'b0, seen_inst}, 64'h0030_0193);
        chk("loop_cycles", 64'(cyc - c0), 64'd12);
        chk("loop_count", inst_count, 64'd3);

`ifdef YSYX_22050612_IFU_MISALIGN_CHECK_EN
        chk("mis_fault", {63'b0, fault}, 64'd1);
        chk("mis_pc", inst_pc, 64'h8000_0002);
        mem_req_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("mis_no_req", {63'b0, mem_req_valid}, 64'd0);
        end
        chk("mis_fault_hold", {63'b0, fault}, 64'd1);
`else
        chk("mis_fault", {63'b0, fault}, 64'd0);
        chk("mis_pc", inst_pc, 64'h8000_0000);
        chk("mis_addr", mem_req_addr, 64'h8000_0000);
        chk("mis_req_valid", {63'b0, mem_req_valid}, 64'd1);
        run_one(64'h0040_0213_0000_0073, 0, 0, 1'b0, 64'h8000_0008);
        chk("mis_inst", {32'b0, seen_inst}, 64'h0000_0073);
        chk("mis_count", inst_count, 64'd4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22050612_ifu.md
# ysyx_22050612_ifu

Multi-cycle instruction fetch unit for the ysyx_22050612 RV64 core. It sits directly upstream of the execute stage. It owns the architectural PC, issues one 64-bit instruction-memory read per instruction over a valid/ready request channel, and extracts the 32-bit instruction word. It presents `{inst, inst_pc}` to decode/execute with a valid/ready handshake, then waits for execute to return the next PC (`dnpc`) before fetching again.

## Interface
Parameters:
- `RESET_PC`, `64'h8000_0000`, PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_req_valid`  out  1  fetch request valid.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_req_addr`  out  64  `{pc[63:3],3'b000}`, 8-byte aligned.
- `mem_rsp_valid`  in  1  read data valid, one-cycle pulse.
- `mem_rsp_data`  in  64  read doubleword.
- `inst_valid`  out  1  instruction available to execute.
- `inst_ready`  in  1  execute accepts instruction.
- `inst`  out  32  fetched instruction.
- `inst_pc`  out  64  PC of `inst`.
- `commit_valid`  in  1  execute has finished; `commit_dnpc` is valid.
- `commit_dnpc`  in  64  next PC from execute.
- `inst_count`  out  64  number of instructions handed to execute.
- `fault`  out  1  sticky misaligned-PC fault. Driven only with the configuration macro; otherwise tied 0.

## Operation
- Registers: `pc`, `state`, `inst`, `inst_count`, `fault`.
- States: IDLE, REQ, WAIT, OUT, EXEC, FAULT.
- IDLE: entered on reset. Moves unconditionally to REQ on the next edge.
- REQ: `mem_req_valid=1` and `mem_req_addr` are held stable until `mem_req_valid & mem_req_ready`. On that handshake, go to WAIT.
- WAIT: on `mem_rsp_valid`, latch `inst <= pc[2] ? mem_rsp_data[63:32] : mem_rsp_data[31:0]` and go to OUT.
- OUT: `inst_valid=1`; `inst` and `inst_pc` are held stable. On `inst_ready`:
  - increment `inst_count` (wraps modulo 2^64),
  - go to EXEC.
- EXEC: wait for `commit_valid`. On it, `pc <= commit_dnpc` and go to REQ.
- FAULT: exists only with the macro. Terminal until reset; no requests are issued, `inst_valid=0`.
- Ignored inputs:
  - `mem_rsp_valid` outside WAIT.
  - `commit_valid` outside EXEC.
  - `inst_ready` outside OUT.
- `inst_pc` is always equal to `pc`.
- A `commit_dnpc` equal to the current PC is legal and refetches the same address.

## Timing
- Reset values (asynchronous, applied immediately while `rst=1`):
  - `pc=RESET_PC`, state IDLE
  - `mem_req_valid=0`, `inst_valid=0`
  - `inst=32'h0`, `inst_count=0`, `fault=0`
- `mem_req_valid` and `inst_valid` are registered state decodes with no combinational path from any input.
- Minimum cycles per instruction, measured from the REQ entry edge with every input responding immediately:
  - REQ 1
  - WAIT 1 (response no earlier than the cycle after request acceptance)
  - OUT 1
  - EXEC 1
  - total 4, back to REQ.
- Request latency: `mem_req_valid` rises on the first edge after reset deasserts.
- `rst` asserted mid-transaction: any outstanding memory response is abandoned. A `mem_rsp_valid` arriving after reset is ignored because state is not WAIT.

## Configuration
- `YSYX_22050612_IFU_MISALIGN_CHECK_EN`.
- Defined:
  - In EXEC, if `commit_valid` and `commit_dnpc[1:0] != 2'b00`, then `pc <= commit_dnpc`, `fault <= 1`, state goes to FAULT.
  - `fault` stays 1 until reset; no further fetches.
- Undefined:
  - `pc` loads `{commit_dnpc[63:2],2'b00}`.
  - `fault` is constant 0 and the FAULT state does not exist.

## Test plan
- **Reset fetch.** Deassert `rst`, with `mem_req_ready=1`.
  - Required: `mem_req_valid=1`, `mem_req_addr=64'h8000_0000` one edge later.
  - Respond with `mem_rsp_data=64'h1111_1111_0000_0413` → `inst=32'h0000_0413`, `inst_pc=64'h8000_0000`.
- **Upper-word select.** Commit `commit_dnpc=64'h8000_0004`.
  - Required: `mem_req_addr=64'h8000_0000`.
  - Respond with `64'h00a0_0513_xxxx_xxxx` → `inst=32'h00a0_0513`.
- **Backpressure.**
  - Hold `mem_req_ready=0` for 5 cycles → address stable, no WAIT entry.
  - Hold `inst_ready=0` for 5 cycles in OUT → `inst`/`inst_valid` stable, `inst_count` unchanged. It increments by exactly 1 on release.
- **Spurious inputs.**
  - Pulse `mem_rsp_valid` in REQ and `commit_valid` in OUT → no state, PC, or `inst` change.
  - Full 4-cycle loop over 3 instructions → `inst_count=3`.
- **Reset mid-WAIT.** Assert `rst` in WAIT, release, then deliver a stale `mem_rsp_valid` in REQ.
  - Required: it is ignored; `pc=RESET_PC`; the fetch restarts cleanly.
- **Misalign** (macro defined). Commit `commit_dnpc=64'h8000_0002`.
  - Required: `fault=1` next edge, `mem_req_valid` stays 0 for ≥10 cycles.
  - Macro undefined: next fetch from `pc=64'h8000_0000`, `fault=0`.
